// File: rtl/sram_mem_arbiter_pkg.sv
// Shared FSM state encoding and request-source constants for sram_mem_arbiter.
package sram_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_D_REQ  = 3'd1,
      ST_D_WAIT = 3'd2,
      ST_I_REQ  = 3'd3,
      ST_I_WAIT = 3'd4,
      ST_DONE   = 3'd5
   } arb_state_e;

   localparam logic MEM_SRC_INST = 1'b0;
   localparam logic MEM_SRC_DATA = 1'b1;

endpackage

// File: rtl/sram_arb_req_latch.sv
// Holds one requester's en/we/addr/wdata; refreshed every cycle while capture is high.
module sram_arb_req_latch
   import sram_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              en_i,
   input  logic [STRB_W-1:0] we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              en_o,
   output logic [STRB_W-1:0] we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] wdata_o
);

   logic              en_q, en_d;
   logic [STRB_W-1:0] we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   always_comb begin
      en_d    = en_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (capture) begin
         en_d    = en_i;
         we_d    = we_i;
         addr_d  = addr_i;
         wdata_d = wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q    <= 1'b0;
         we_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign en_o    = en_q;
   assign we_o    = we_q;
   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;

endmodule

// File: rtl/sram_mem_arbiter.sv
// Serialises data-then-instruction SRAM accesses onto one memory port, stalling the pipeline meanwhile.
// Optional: define SRAM_ARB_IFETCH_REUSE_EN to skip refetching the last instruction address.
module sram_mem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_sram_en,
   input  logic [STRB_W-1:0] inst_sram_we,
   input  logic [ADDR_W-1:0] inst_sram_addr,
   input  logic [DATA_W-1:0] inst_sram_wdata,
   output logic [DATA_W-1:0] inst_sram_rdata,
   input  logic              data_sram_en,
   input  logic [STRB_W-1:0] data_sram_we,
   input  logic [ADDR_W-1:0] data_sram_addr,
   input  logic [DATA_W-1:0] data_sram_wdata,
   output logic [DATA_W-1:0] data_sram_rdata,
   output logic              stallreq_axi,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_src,
   output logic [STRB_W-1:0] mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata
);
   import sram_mem_arbiter_pkg::*;

   arb_state_e        state_q, state_d;
   logic              mem_req_valid_q, mem_req_valid_d;
   logic              mem_req_src_q, mem_req_src_d;
   logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

   logic              capture;
   logic              i_en, d_en;
   logic [STRB_W-1:0] i_we, d_we;
   logic [ADDR_W-1:0] i_addr, d_addr;
   logic [DATA_W-1:0] i_wdata, d_wdata;
   logic              ifetch_hit_idle, ifetch_hit_dwait;

   assign capture = (state_q == ST_IDLE);

   sram_arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) u_inst_latch (
      .clk(clk), .rst(rst), .capture(capture),
      .en_i(inst_sram_en), .we_i(inst_sram_we), .addr_i(inst_sram_addr), .wdata_i(inst_sram_wdata),
      .en_o(i_en), .we_o(i_we), .addr_o(i_addr), .wdata_o(i_wdata)
   );

   sram_arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) u_data_latch (
      .clk(clk), .rst(rst), .capture(capture),
      .en_i(data_sram_en), .we_i(data_sram_we), .addr_i(data_sram_addr), .wdata_i(data_sram_wdata),
      .en_o(d_en), .we_o(d_we), .addr_o(d_addr), .wdata_o(d_wdata)
   );

`ifdef SRAM_ARB_IFETCH_REUSE_EN
   logic [ADDR_W-1:0] last_iaddr_q, last_iaddr_d;
   logic              last_ivalid_q, last_ivalid_d;
   logic              store_clear;

   // A store into the same 8-byte word as the cached fetch invalidates it before the fetch decision.
   always_comb begin
      last_iaddr_d  = last_iaddr_q;
      last_ivalid_d = last_ivalid_q;
      store_clear   = (state_q == ST_D_WAIT) && mem_rsp_valid && (d_we != '0) &&
                      (d_addr[ADDR_W-1:3] == last_iaddr_q[ADDR_W-1:3]);
      if ((state_q == ST_I_WAIT) && mem_rsp_valid) begin
         last_iaddr_d  = i_addr;
         last_ivalid_d = 1'b1;
      end else if (store_clear) begin
         last_ivalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_iaddr_q  <= '0;
         last_ivalid_q <= 1'b0;
      end else begin
         last_iaddr_q  <= last_iaddr_d;
         last_ivalid_q <= last_ivalid_d;
      end
   end

   assign ifetch_hit_idle  = last_ivalid_q && (inst_sram_addr == last_iaddr_q);
   assign ifetch_hit_dwait = last_ivalid_q && !store_clear && (i_addr == last_iaddr_q);
`else
   assign ifetch_hit_idle  = 1'b0;
   assign ifetch_hit_dwait = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_req_src_d   = mem_req_src_q;
      inst_rdata_d    = inst_rdata_q;
      data_rdata_d    = data_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (data_sram_en) begin
               state_d         = ST_D_REQ;
               mem_req_valid_d = 1'b1;
               mem_req_src_d   = MEM_SRC_DATA;
            end else if (inst_sram_en) begin
               if (ifetch_hit_idle) begin
                  state_d = ST_DONE;
               end else begin
                  state_d         = ST_I_REQ;
                  mem_req_valid_d = 1'b1;
                  mem_req_src_d   = MEM_SRC_INST;
               end
            end
         end
         ST_D_REQ: begin
            if (mem_req_ready) begin
               state_d         = ST_D_WAIT;
               mem_req_valid_d = 1'b0;
            end
         end
         ST_D_WAIT: begin
            if (mem_rsp_valid) begin
               if (d_en && (d_we == '0)) data_rdata_d = mem_rsp_rdata;
               if (i_en && !ifetch_hit_dwait) begin
                  state_d         = ST_I_REQ;
                  mem_req_valid_d = 1'b1;
                  mem_req_src_d   = MEM_SRC_INST;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_I_REQ: begin
            if (mem_req_ready) begin
               state_d         = ST_I_WAIT;
               mem_req_valid_d = 1'b0;
            end
         end
         ST_I_WAIT: begin
            if (mem_rsp_valid) begin
               inst_rdata_d = mem_rsp_rdata;
               state_d      = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: begin
            state_d         = ST_IDLE;
            mem_req_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         mem_req_valid_q <= 1'b0;
         mem_req_src_q   <= MEM_SRC_INST;
         inst_rdata_q    <= '0;
         data_rdata_q    <= '0;
      end else begin
         state_q         <= state_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_src_q   <= mem_req_src_d;
         inst_rdata_q    <= inst_rdata_d;
         data_rdata_q    <= data_rdata_d;
      end
   end

   always_comb begin
      stallreq_axi = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_IDLE: stallreq_axi = inst_sram_en | data_sram_en;
            ST_DONE: stallreq_axi = 1'b0;
            default: stallreq_axi = 1'b1;
         endcase
      end
   end

   assign mem_req_valid   = mem_req_valid_q;
   assign mem_req_src     = mem_req_src_q;
   assign mem_req_we      = (mem_req_src_q == MEM_SRC_DATA) ? d_we    : i_we;
   assign mem_req_addr    = (mem_req_src_q == MEM_SRC_DATA) ? d_addr  : i_addr;
   assign mem_req_wdata   = (mem_req_src_q == MEM_SRC_DATA) ? d_wdata : i_wdata;
   assign inst_sram_rdata = inst_rdata_q;
   assign data_sram_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Directed bench for sram_mem_arbiter with a transaction-level model and a memory responder.
`timescale 1ns/1ps
module tb_sram_mem_arbiter;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int STRB_W = 8;
`ifdef SRAM_ARB_IFETCH_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif
   localparam logic [63:0] IWDATA = 64'hA5A5_5A5A_0F0F_F0F0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              inst_sram_en = 1'b0;
   logic [STRB_W-1:0] inst_sram_we = '0;
   logic [ADDR_W-1:0] inst_sram_addr = '0;
   logic [DATA_W-1:0] inst_sram_wdata = '0;
   logic [DATA_W-1:0] inst_sram_rdata;
   logic              data_sram_en = 1'b0;
   logic [STRB_W-1:0] data_sram_we = '0;
   logic [ADDR_W-1:0] data_sram_addr = '0;
   logic [DATA_W-1:0] data_sram_wdata = '0;
   logic [DATA_W-1:0] data_sram_rdata;
   logic              stallreq_axi;
   logic              mem_req_valid;
   logic              mem_req_ready = 1'b1;
   logic              mem_req_src;
   logic [STRB_W-1:0] mem_req_we;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [DATA_W-1:0] mem_req_wdata;
   logic              mem_rsp_valid = 1'b0;
   logic [DATA_W-1:0] mem_rsp_rdata = '0;

   sram_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
      .clk(clk), .rst(rst),
      .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we), .inst_sram_addr(inst_sram_addr),
      .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
      .data_sram_en(data_sram_en), .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
      .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
      .stallreq_axi(stallreq_axi),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_src(mem_req_src),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              src;
      logic [STRB_W-1:0] we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] rsp;
   } req_t;

   req_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   logic [63:0] m_irdata = '0, m_drdata = '0, m_liaddr = '0;
   logic        m_lvalid = 1'b0;
   int          hold_cnt = 0, rsp_delay = 0;
   logic        spur_en = 1'b0, rsp_drop = 1'b0, chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare of DUT outputs against the model
   always @(negedge clk) begin
      req_t h;
      if (chk_en && !rst) begin
         chk("inst_rdata", inst_sram_rdata, m_irdata);
         chk("data_rdata", data_sram_rdata, m_drdata);
         if (mem_req_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_req", 64'(mem_req_valid), 64'd0);
            end else begin
               h = exp_q[0];
               chk("req_src", 64'(mem_req_src), 64'(h.src));
               chk("req_we", 64'(mem_req_we), 64'(h.we));
               chk("req_addr", mem_req_addr, h.addr);
               chk("req_wdata", mem_req_wdata, h.wdata);
            end
         end
      end
   end

   // Downstream memory: optional backpressure, delayed or spurious responses
   initial begin
      req_t cur;
      logic acc, vld, pending, active;
      int   wait_cnt;
      pending = 1'b0; active = 1'b0; wait_cnt = 0;
      cur = '{src: 1'b0, we: '0, addr: '0, wdata: '0, rsp: '0};
      forever begin
         @(negedge clk);
         acc = !rst && mem_req_valid && mem_req_ready;
         vld = !rst && mem_req_valid;
         @(posedge clk);
         #1;
         if (active) begin
            if (!rsp_drop) begin
               if (cur.src == 1'b0) m_irdata = cur.rsp;
               else if (cur.we == '0) m_drdata = cur.rsp;
            end
            active = 1'b0;
         end
         mem_rsp_valid = 1'b0;
         mem_rsp_rdata = '0;
         if (acc && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            wait_cnt = rsp_delay;
            pending = 1'b1;
            rsp_drop = 1'b0;
            spur_en = 1'b0;
         end
         if (pending) begin
            if (wait_cnt == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_rdata = cur.rsp;
               active = 1'b1;
               pending = 1'b0;
            end else begin
               wait_cnt--;
            end
         end else if (spur_en) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 64'h55;
         end
         if (vld && !acc && hold_cnt > 0) hold_cnt--;
         mem_req_ready = (hold_cnt == 0);
      end
   end

   task automatic do_op(input logic den, input logic [7:0] dwe, input logic [63:0] daddr,
                        input logic [63:0] dwdata, input logic [63:0] drsp,
                        input logic ien, input logic [63:0] iaddr, input logic [63:0] irsp,
                        input int hold, input int dly, input logic spur, output int stalls);
      int   exp_stalls;
      logic hit, done;
      @(negedge clk);
      hold_cnt = hold;
      rsp_delay = dly;
      spur_en = spur;
      exp_stalls = 1 + hold;
      if (den) begin
         exp_q.push_back('{src: 1'b1, we: dwe, addr: daddr, wdata: dwdata, rsp: drsp});
         exp_stalls += 2 + dly;
         if (dwe != '0 && daddr[63:3] == m_liaddr[63:3]) m_lvalid = 1'b0;
      end
      if (ien) begin
         hit = REUSE && m_lvalid && (iaddr == m_liaddr);
         if (!hit) begin
            exp_q.push_back('{src: 1'b0, we: '0, addr: iaddr, wdata: IWDATA, rsp: irsp});
            exp_stalls += 2 + dly;
         end
         m_liaddr = iaddr;
         m_lvalid = 1'b1;
      end
      @(posedge clk);
      #1;
      data_sram_en = den; data_sram_we = dwe; data_sram_addr = daddr; data_sram_wdata = dwdata;
      inst_sram_en = ien; inst_sram_we = '0; inst_sram_addr = iaddr; inst_sram_wdata = IWDATA;
      stalls = 0;
      done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (stallreq_axi) stalls++;
         else begin
            done = 1'b1;
            break;
         end
      end
      chk("stall_bounded", 64'(done), 64'd1);
      chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
      chk("all_reqs_issued", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
      data_sram_en = 1'b0;
      inst_sram_en = 1'b0;
      spur_en = 1'b0;
      @(negedge clk);
      chk("idle_stall", 64'(stallreq_axi), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      rst = 1'b1;
      data_sram_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 64'(stallreq_axi), 64'd0);
      chk("rst_valid", 64'(mem_req_valid), 64'd0);
      chk("rst_irdata", inst_sram_rdata, 64'd0);
      chk("rst_drdata", data_sram_rdata, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      data_sram_en = 1'b0;
      chk_en = 1'b1;

      do_op(1'b1, 8'h00, 64'h8000_1000, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'h0, 64'h0, 0, 0, 1'b0, st);
      chk("load_stall_lit", 64'(st), 64'd3);
      chk("load_rdata_lit", data_sram_rdata, 64'hDEAD_BEEF_CAFE_F00D);

      do_op(1'b1, 8'hFF, 64'h8000_2000, 64'h1122_3344_5566_7788, 64'hBAD0_BAD0_BAD0_BAD0,
            1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0, st);
      chk("both_stall_lit", 64'(st), 64'd5);
      chk("both_irdata_lit", inst_sram_rdata, 64'h0123_4567_89AB_CDEF);
      chk("store_keeps_drdata_lit", data_sram_rdata, 64'hDEAD_BEEF_CAFE_F00D);

      do_op(1'b1, 8'h00, 64'h8000_3000, 64'h0, 64'h0F0F_0F0F_1234_5678, 1'b0, 64'h0, 64'h0, 4, 0, 1'b0, st);
      chk("backpressure_stall_lit", 64'(st), 64'd7);

      do_op(1'b1, 8'h00, 64'h8000_3008, 64'h0, 64'hCAFE_0000_0000_0001, 1'b0, 64'h0, 64'h0, 2, 0, 1'b1, st);
      chk("spurious_rdata_lit", data_sram_rdata, 64'hCAFE_0000_0000_0001);

      do_op(1'b0, 8'h00, 64'h0, 64'h0, 64'h0, 1'b1, 64'h8000_0040, 64'h1111_1111_1111_1111, 0, 0, 1'b0, st);
      do_op(1'b1, 8'h0F, 64'h8000_0044, 64'h9999_8888_7777_6666, 64'h0, 1'b0, 64'h0, 64'h0, 0, 0, 1'b0, st);
      do_op(1'b0, 8'h00, 64'h0, 64'h0, 64'h0, 1'b1, 64'h8000_0040, 64'h2222_2222_2222_2222, 0, 0, 1'b0, st);
      chk("refetch_after_store_lit", 64'(st), 64'd3);
      do_op(1'b0, 8'h00, 64'h0, 64'h0, 64'h0, 1'b1, 64'h8000_0040, 64'h3333_3333_3333_3333, 0, 0, 1'b0, st);
      chk("reuse_stall_lit", 64'(st), REUSE ? 64'd1 : 64'd3);
      chk("reuse_irdata_lit", inst_sram_rdata, REUSE ? 64'h2222_2222_2222_2222 : 64'h3333_3333_3333_3333);
      do_op(1'b1, 8'h00, 64'h8000_4000, 64'h0, 64'h4444_4444_4444_4444,
            1'b1, 64'h8000_0040, 64'h5555_5555_5555_5555, 0, 1, 1'b0, st);

      // Reset while the fetch response is outstanding
      @(negedge clk);
      rsp_delay = 3;
      hold_cnt = 0;
      exp_q.push_back('{src: 1'b0, we: '0, addr: 64'h8000_0080, wdata: IWDATA, rsp: 64'h7777_7777_7777_7777});
      @(posedge clk);
      #1;
      inst_sram_en = 1'b1; inst_sram_we = '0; inst_sram_addr = 64'h8000_0080; inst_sram_wdata = IWDATA;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rstmid_wait_stall", 64'(stallreq_axi), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      rsp_drop = 1'b1;
      @(negedge clk);
      chk("rstmid_stall_in_rst", 64'(stallreq_axi), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      inst_sram_en = 1'b0;
      m_irdata = '0; m_drdata = '0; m_lvalid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("rstmid_valid", 64'(mem_req_valid), 64'd0);
      chk("rstmid_stall", 64'(stallreq_axi), 64'd0);
      chk("rstmid_irdata", inst_sram_rdata, 64'd0);
      chk("rstmid_drdata", data_sram_rdata, 64'd0);
      repeat (4) @(negedge clk);
      chk("late_rsp_ignored", inst_sram_rdata, 64'd0);
      chk("late_rsp_stall", 64'(stallreq_axi), 64'd0);

      do_op(1'b1, 8'h00, 64'h8000_5000, 64'h0, 64'h1357_9BDF_2468_ACE0, 1'b0, 64'h0, 64'h0, 0, 0, 1'b0, st);
      chk("recover_rdata_lit", data_sram_rdata, 64'h1357_9BDF_2468_ACE0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
